// File: rtl/axil_xbar_rr.sv
// NUM_MASTER x NUM_SLAVE AXI4-Lite crossbar; independent round-robin read and write paths, 1-cycle grant.
// Optional AXIL_XBAR_DECERR_EN: unmapped addresses hit an internal DECERR responder instead of slave 0.
module axil_xbar_rr #(
    parameter int NUM_MASTER = 2,
    parameter int NUM_SLAVE  = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter logic [NUM_SLAVE*ADDR_W-1:0] SLV_BASE = {32'h10, 32'h0},
    parameter logic [NUM_SLAVE*ADDR_W-1:0] SLV_MASK = {32'hFFFFFFF0, 32'hFFFFFFF0}
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [NUM_MASTER*ADDR_W-1:0]     mst_awaddr,
    input  logic [NUM_MASTER-1:0]            mst_awvalid,
    output logic [NUM_MASTER-1:0]            mst_awready,
    input  logic [NUM_MASTER*DATA_W-1:0]     mst_wdata,
    input  logic [NUM_MASTER*DATA_W/8-1:0]   mst_wstrb,
    input  logic [NUM_MASTER-1:0]            mst_wvalid,
    output logic [NUM_MASTER-1:0]            mst_wready,
    output logic [NUM_MASTER*2-1:0]          mst_bresp,
    output logic [NUM_MASTER-1:0]            mst_bvalid,
    input  logic [NUM_MASTER-1:0]            mst_bready,
    input  logic [NUM_MASTER*ADDR_W-1:0]     mst_araddr,
    input  logic [NUM_MASTER-1:0]            mst_arvalid,
    output logic [NUM_MASTER-1:0]            mst_arready,
    output logic [NUM_MASTER*DATA_W-1:0]     mst_rdata,
    output logic [NUM_MASTER*2-1:0]          mst_rresp,
    output logic [NUM_MASTER-1:0]            mst_rvalid,
    input  logic [NUM_MASTER-1:0]            mst_rready,
    output logic [NUM_SLAVE*ADDR_W-1:0]      slv_awaddr,
    output logic [NUM_SLAVE-1:0]             slv_awvalid,
    input  logic [NUM_SLAVE-1:0]             slv_awready,
    output logic [NUM_SLAVE*DATA_W-1:0]      slv_wdata,
    output logic [NUM_SLAVE*DATA_W/8-1:0]    slv_wstrb,
    output logic [NUM_SLAVE-1:0]             slv_wvalid,
    input  logic [NUM_SLAVE-1:0]             slv_wready,
    input  logic [NUM_SLAVE*2-1:0]           slv_bresp,
    input  logic [NUM_SLAVE-1:0]             slv_bvalid,
    output logic [NUM_SLAVE-1:0]             slv_bready,
    output logic [NUM_SLAVE*ADDR_W-1:0]      slv_araddr,
    output logic [NUM_SLAVE-1:0]             slv_arvalid,
    input  logic [NUM_SLAVE-1:0]             slv_arready,
    input  logic [NUM_SLAVE*DATA_W-1:0]      slv_rdata,
    input  logic [NUM_SLAVE*2-1:0]           slv_rresp,
    input  logic [NUM_SLAVE-1:0]             slv_rvalid,
    output logic [NUM_SLAVE-1:0]             slv_rready
);
    localparam int STRB_W = DATA_W / 8;
    localparam int MI_W   = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;
    localparam int SI_W   = (NUM_SLAVE > 1) ? $clog2(NUM_SLAVE) : 1;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

    // First requester strictly after ptr, wrapping; ptr holds the last winner.
    function automatic logic [MI_W-1:0] rr_pick(input logic [NUM_MASTER-1:0] req,
                                                input logic [MI_W-1:0] ptr);
        logic [MI_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_MASTER; k++) begin
            idx = (int'(ptr) + k) % NUM_MASTER;
            if (!found && req[idx]) begin
                pick  = MI_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [SI_W-1:0] dec_sel(input logic [ADDR_W-1:0] a);
        logic [SI_W-1:0] sel;
        sel = '0;
        for (int j = NUM_SLAVE - 1; j >= 0; j--)
            if ((a & SLV_MASK[j*ADDR_W +: ADDR_W]) == SLV_BASE[j*ADDR_W +: ADDR_W])
                sel = SI_W'(j);
        return sel;
    endfunction

`ifdef AXIL_XBAR_DECERR_EN
    function automatic logic dec_hit(input logic [ADDR_W-1:0] a);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < NUM_SLAVE; j++)
            if ((a & SLV_MASK[j*ADDR_W +: ADDR_W]) == SLV_BASE[j*ADDR_W +: ADDR_W])
                hit = 1'b1;
        return hit;
    endfunction
    logic w_err, w_err_nxt, r_err, r_err_nxt;
`endif

    w_state_t        w_state, w_state_nxt;
    r_state_t        r_state, r_state_nxt;
    logic [MI_W-1:0] wgnt, wgnt_nxt, wptr, wptr_nxt, rgnt, rgnt_nxt, rptr, rptr_nxt;
    logic [SI_W-1:0] wsel, wsel_nxt, rsel, rsel_nxt;
    logic            aw_done, aw_done_nxt, w_done, w_done_nxt;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            wgnt    <= '0;
            rgnt    <= '0;
            wsel    <= '0;
            rsel    <= '0;
            wptr    <= MI_W'(NUM_MASTER - 1);
            rptr    <= MI_W'(NUM_MASTER - 1);
            aw_done <= 1'b0;
            w_done  <= 1'b0;
`ifdef AXIL_XBAR_DECERR_EN
            w_err   <= 1'b0;
            r_err   <= 1'b0;
`endif
        end else begin
            w_state <= w_state_nxt;
            r_state <= r_state_nxt;
            wgnt    <= wgnt_nxt;
            rgnt    <= rgnt_nxt;
            wsel    <= wsel_nxt;
            rsel    <= rsel_nxt;
            wptr    <= wptr_nxt;
            rptr    <= rptr_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
`ifdef AXIL_XBAR_DECERR_EN
            w_err   <= w_err_nxt;
            r_err   <= r_err_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = w_state;
        wgnt_nxt    = wgnt;
        wsel_nxt    = wsel;
        wptr_nxt    = wptr;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        mst_awready = '0;
        mst_wready  = '0;
        mst_bvalid  = '0;
        mst_bresp   = '0;
        slv_awaddr  = '0;
        slv_awvalid = '0;
        slv_wdata   = '0;
        slv_wstrb   = '0;
        slv_wvalid  = '0;
        slv_bready  = '0;
`ifdef AXIL_XBAR_DECERR_EN
        w_err_nxt   = w_err;
`endif
        case (w_state)
            W_IDLE: if (|mst_awvalid) begin
                wgnt_nxt    = rr_pick(mst_awvalid, wptr);
                wsel_nxt    = dec_sel(mst_awaddr[int'(wgnt_nxt)*ADDR_W +: ADDR_W]);
                wptr_nxt    = wgnt_nxt;
                aw_done_nxt = 1'b0;
                w_done_nxt  = 1'b0;
`ifdef AXIL_XBAR_DECERR_EN
                w_err_nxt   = !dec_hit(mst_awaddr[int'(wgnt_nxt)*ADDR_W +: ADDR_W]);
`endif
                w_state_nxt = W_ADDR;
            end
            W_ADDR: begin
`ifdef AXIL_XBAR_DECERR_EN
                if (w_err) begin
                    mst_awready[wgnt] = !aw_done;
                    mst_wready[wgnt]  = !w_done;
                end else
`endif
                begin
                    // Each channel is forwarded only until its own handshake.
                    slv_awaddr[int'(wsel)*ADDR_W +: ADDR_W] = mst_awaddr[int'(wgnt)*ADDR_W +: ADDR_W];
                    slv_awvalid[wsel] = mst_awvalid[wgnt] & !aw_done;
                    mst_awready[wgnt] = slv_awready[wsel] & !aw_done;
                    slv_wdata[int'(wsel)*DATA_W +: DATA_W] = mst_wdata[int'(wgnt)*DATA_W +: DATA_W];
                    slv_wstrb[int'(wsel)*STRB_W +: STRB_W] = mst_wstrb[int'(wgnt)*STRB_W +: STRB_W];
                    slv_wvalid[wsel]  = mst_wvalid[wgnt] & !w_done;
                    mst_wready[wgnt]  = slv_wready[wsel] & !w_done;
                end
                aw_done_nxt = aw_done | (mst_awvalid[wgnt] & mst_awready[wgnt]);
                w_done_nxt  = w_done | (mst_wvalid[wgnt] & mst_wready[wgnt]);
                if (aw_done_nxt && w_done_nxt)
                    w_state_nxt = W_RESP;
            end
            W_RESP: begin
`ifdef AXIL_XBAR_DECERR_EN
                if (w_err) begin
                    mst_bvalid[wgnt] = 1'b1;
                    mst_bresp[int'(wgnt)*2 +: 2] = 2'b11;
                end else
`endif
                begin
                    mst_bvalid[wgnt] = slv_bvalid[wsel];
                    mst_bresp[int'(wgnt)*2 +: 2] = slv_bresp[int'(wsel)*2 +: 2];
                    slv_bready[wsel] = mst_bready[wgnt];
                end
                if (mst_bvalid[wgnt] && mst_bready[wgnt])
                    w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_nxt = r_state;
        rgnt_nxt    = rgnt;
        rsel_nxt    = rsel;
        rptr_nxt    = rptr;
        mst_arready = '0;
        mst_rvalid  = '0;
        mst_rdata   = '0;
        mst_rresp   = '0;
        slv_araddr  = '0;
        slv_arvalid = '0;
        slv_rready  = '0;
`ifdef AXIL_XBAR_DECERR_EN
        r_err_nxt   = r_err;
`endif
        case (r_state)
            R_IDLE: if (|mst_arvalid) begin
                rgnt_nxt    = rr_pick(mst_arvalid, rptr);
                rsel_nxt    = dec_sel(mst_araddr[int'(rgnt_nxt)*ADDR_W +: ADDR_W]);
                rptr_nxt    = rgnt_nxt;
`ifdef AXIL_XBAR_DECERR_EN
                r_err_nxt   = !dec_hit(mst_araddr[int'(rgnt_nxt)*ADDR_W +: ADDR_W]);
`endif
                r_state_nxt = R_ADDR;
            end
            R_ADDR: begin
`ifdef AXIL_XBAR_DECERR_EN
                if (r_err) begin
                    mst_arready[rgnt] = 1'b1;
                end else
`endif
                begin
                    slv_araddr[int'(rsel)*ADDR_W +: ADDR_W] = mst_araddr[int'(rgnt)*ADDR_W +: ADDR_W];
                    slv_arvalid[rsel] = mst_arvalid[rgnt];
                    mst_arready[rgnt] = slv_arready[rsel];
                end
                if (mst_arvalid[rgnt] && mst_arready[rgnt])
                    r_state_nxt = R_DATA;
            end
            R_DATA: begin
`ifdef AXIL_XBAR_DECERR_EN
                if (r_err) begin
                    mst_rvalid[rgnt] = 1'b1;
                    mst_rresp[int'(rgnt)*2 +: 2] = 2'b11;
                end else
`endif
                begin
                    mst_rvalid[rgnt] = slv_rvalid[rsel];
                    mst_rdata[int'(rgnt)*DATA_W +: DATA_W] = slv_rdata[int'(rsel)*DATA_W +: DATA_W];
                    mst_rresp[int'(rgnt)*2 +: 2] = slv_rresp[int'(rsel)*2 +: 2];
                    slv_rready[rsel] = mst_rready[rgnt];
                end
                if (mst_rvalid[rgnt] && mst_rready[rgnt])
                    r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end
endmodule

// File: tb/tb_axil_xbar_rr.sv
// Scoreboard bench for axil_xbar_rr: directed transactions push expected slave events and master responses.
module tb_axil_xbar_rr;
    localparam int NM = 2, NS = 2, AW = 32, DW = 32, SW = 4;

    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    logic [NM*AW-1:0] mst_awaddr, mst_araddr;
    logic [NM-1:0]    mst_awvalid, mst_wvalid, mst_arvalid, mst_bready, mst_rready;
    logic [NM*DW-1:0] mst_wdata, mst_rdata;
    logic [NM*SW-1:0] mst_wstrb;
    logic [NM-1:0]    mst_awready, mst_wready, mst_arready, mst_bvalid, mst_rvalid;
    logic [NM*2-1:0]  mst_bresp, mst_rresp;
    logic [NS*AW-1:0] slv_awaddr, slv_araddr;
    logic [NS-1:0]    slv_awvalid, slv_wvalid, slv_arvalid, slv_bready, slv_rready;
    logic [NS*DW-1:0] slv_wdata, slv_rdata;
    logic [NS*SW-1:0] slv_wstrb;
    logic [NS-1:0]    slv_awready, slv_wready, slv_arready, slv_bvalid, slv_rvalid;
    logic [NS*2-1:0]  slv_bresp, slv_rresp;

    axil_xbar_rr dut (
        .aclk(aclk), .areset(areset),
        .mst_awaddr(mst_awaddr), .mst_awvalid(mst_awvalid), .mst_awready(mst_awready),
        .mst_wdata(mst_wdata), .mst_wstrb(mst_wstrb), .mst_wvalid(mst_wvalid), .mst_wready(mst_wready),
        .mst_bresp(mst_bresp), .mst_bvalid(mst_bvalid), .mst_bready(mst_bready),
        .mst_araddr(mst_araddr), .mst_arvalid(mst_arvalid), .mst_arready(mst_arready),
        .mst_rdata(mst_rdata), .mst_rresp(mst_rresp), .mst_rvalid(mst_rvalid), .mst_rready(mst_rready),
        .slv_awaddr(slv_awaddr), .slv_awvalid(slv_awvalid), .slv_awready(slv_awready),
        .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb), .slv_wvalid(slv_wvalid), .slv_wready(slv_wready),
        .slv_bresp(slv_bresp), .slv_bvalid(slv_bvalid), .slv_bready(slv_bready),
        .slv_araddr(slv_araddr), .slv_arvalid(slv_arvalid), .slv_arready(slv_arready),
        .slv_rdata(slv_rdata), .slv_rresp(slv_rresp), .slv_rvalid(slv_rvalid), .slv_rready(slv_rready)
    );

    // Per-master drive arrays so concurrent tasks never share a variable.
    logic [AW-1:0] m_awaddr [NM];
    logic [AW-1:0] m_araddr [NM];
    logic [DW-1:0] m_wdata  [NM];
    logic [SW-1:0] m_wstrb  [NM];
    logic          m_awvalid[NM];
    logic          m_wvalid [NM];
    logic          m_arvalid[NM];

    always_comb begin
        for (int i = 0; i < NM; i++) begin
            mst_awaddr[i*AW +: AW] = m_awaddr[i];
            mst_araddr[i*AW +: AW] = m_araddr[i];
            mst_wdata[i*DW +: DW]  = m_wdata[i];
            mst_wstrb[i*SW +: SW]  = m_wstrb[i];
            mst_awvalid[i]         = m_awvalid[i];
            mst_wvalid[i]          = m_wvalid[i];
            mst_arvalid[i]         = m_arvalid[i];
        end
    end
    assign mst_bready  = '1;
    assign mst_rready  = '1;
    assign slv_awready = '1;
    assign slv_wready  = '1;
    assign slv_arready = '1;

    typedef struct packed {
        logic [7:0]    slv;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
    } sev_t;

    int   checks = 0;
    int   failures = 0;
    sev_t exp_sw[$];
    sev_t exp_sr[$];
    logic [1:0]    exp_b[NM][$];
    logic [DW+1:0] exp_r[NM][$];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [79:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got %h expected nothing", name, act);
    endtask

    function automatic sev_t mk(input int s, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic [SW-1:0] st);
        sev_t e;
        e.slv = 8'(s); e.addr = a; e.data = d; e.strb = st;
        return e;
    endfunction

    function automatic logic any_out();
        return |{mst_awready, mst_wready, mst_arready, mst_bvalid, mst_rvalid, mst_bresp, mst_rresp,
                 mst_rdata, slv_awaddr, slv_araddr, slv_awvalid, slv_wvalid, slv_arvalid, slv_bready,
                 slv_rready, slv_wdata, slv_wstrb};
    endfunction

    function automatic int pending();
        return exp_sw.size() + exp_sr.size() + exp_b[0].size() + exp_b[1].size()
             + exp_r[0].size() + exp_r[1].size();
    endfunction

    // Slave models: always ready; B after both AW and W, R one cycle after AR. Slave j answers
    // bresp=j and rdata=0xCAFE0000+j so routing mistakes are visible at the master.
    initial begin
        logic          got_aw[NS], got_w[NS], aw_hs[NS], w_hs[NS], b_hs[NS], ar_hs[NS], r_hs[NS];
        logic [AW-1:0] sa[NS], aw_a[NS], ar_a[NS];
        logic [DW-1:0] sd[NS], w_d[NS];
        logic [SW-1:0] ss[NS], w_s[NS];
        slv_bvalid = '0; slv_rvalid = '0; slv_bresp = '0; slv_rresp = '0; slv_rdata = '0;
        for (int j = 0; j < NS; j++) begin got_aw[j] = 1'b0; got_w[j] = 1'b0; end
        forever begin
            @(negedge aclk);
            for (int j = 0; j < NS; j++) begin
                aw_hs[j] = slv_awvalid[j] & slv_awready[j];
                aw_a[j]  = slv_awaddr[j*AW +: AW];
                w_hs[j]  = slv_wvalid[j] & slv_wready[j];
                w_d[j]   = slv_wdata[j*DW +: DW];
                w_s[j]   = slv_wstrb[j*SW +: SW];
                b_hs[j]  = slv_bvalid[j] & slv_bready[j];
                ar_hs[j] = slv_arvalid[j] & slv_arready[j];
                ar_a[j]  = slv_araddr[j*AW +: AW];
                r_hs[j]  = slv_rvalid[j] & slv_rready[j];
            end
            @(posedge aclk);
            #1;
            for (int j = 0; j < NS; j++) begin
                if (areset) begin
                    got_aw[j] = 1'b0; got_w[j] = 1'b0; slv_bvalid[j] = 1'b0; slv_rvalid[j] = 1'b0;
                end else begin
                    if (aw_hs[j]) begin got_aw[j] = 1'b1; sa[j] = aw_a[j]; end
                    if (w_hs[j]) begin got_w[j] = 1'b1; sd[j] = w_d[j]; ss[j] = w_s[j]; end
                    if (b_hs[j]) slv_bvalid[j] = 1'b0;
                    if (got_aw[j] && got_w[j] && !slv_bvalid[j]) begin
                        got_aw[j] = 1'b0; got_w[j] = 1'b0;
                        slv_bvalid[j] = 1'b1;
                        slv_bresp[j*2 +: 2] = 2'(j);
                        if (exp_sw.size() == 0) unexpected("slv_write", mk(j, sa[j], sd[j], ss[j]));
                        else chk("slv_write", mk(j, sa[j], sd[j], ss[j]), exp_sw.pop_front());
                    end
                    if (r_hs[j]) slv_rvalid[j] = 1'b0;
                    if (ar_hs[j]) begin
                        slv_rvalid[j] = 1'b1;
                        slv_rdata[j*DW +: DW] = 32'hCAFE0000 + DW'(j);
                        slv_rresp[j*2 +: 2] = 2'b00;
                        if (exp_sr.size() == 0) unexpected("slv_read", mk(j, ar_a[j], 0, 0));
                        else chk("slv_read", mk(j, ar_a[j], 0, 0), exp_sr.pop_front());
                    end
                end
            end
        end
    end

    // Master-side monitor.
    initial begin
        forever begin
            @(negedge aclk);
            for (int m = 0; m < NM; m++) begin
                if (mst_bvalid[m] && mst_bready[m]) begin
                    if (exp_b[m].size() == 0) unexpected($sformatf("bresp_m%0d", m), mst_bresp[m*2 +: 2]);
                    else chk($sformatf("bresp_m%0d", m), mst_bresp[m*2 +: 2], exp_b[m].pop_front());
                end
                if (mst_rvalid[m] && mst_rready[m]) begin
                    if (exp_r[m].size() == 0)
                        unexpected($sformatf("rdata_m%0d", m), {mst_rdata[m*DW +: DW], mst_rresp[m*2 +: 2]});
                    else chk($sformatf("rdata_m%0d", m), {mst_rdata[m*DW +: DW], mst_rresp[m*2 +: 2]},
                             exp_r[m].pop_front());
                end
            end
        end
    end

    task automatic wr(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [SW-1:0] s, input int wdly);
        fork
            begin
                int n = 0;
                logic hs = 1'b0;
                m_awaddr[m] = a; m_awvalid[m] = 1'b1;
                while (!hs && n < 100) begin
                    @(negedge aclk); hs = mst_awready[m];
                    @(posedge aclk); #1; n++;
                end
                m_awvalid[m] = 1'b0;
                if (!hs) unexpected($sformatf("aw_timeout_m%0d", m), a);
            end
            begin
                int n = 0;
                logic hs = 1'b0;
                repeat (wdly) begin @(posedge aclk); #1; end
                m_wdata[m] = d; m_wstrb[m] = s; m_wvalid[m] = 1'b1;
                while (!hs && n < 100) begin
                    @(negedge aclk); hs = mst_wready[m];
                    @(posedge aclk); #1; n++;
                end
                m_wvalid[m] = 1'b0;
                if (!hs) unexpected($sformatf("w_timeout_m%0d", m), d);
            end
        join
    endtask

    task automatic rd(input int m, input logic [AW-1:0] a);
        int n = 0;
        logic hs = 1'b0;
        m_araddr[m] = a; m_arvalid[m] = 1'b1;
        while (!hs && n < 100) begin
            @(negedge aclk); hs = mst_arready[m];
            @(posedge aclk); #1; n++;
        end
        m_arvalid[m] = 1'b0;
        if (!hs) unexpected($sformatf("ar_timeout_m%0d", m), a);
    endtask

    task automatic drain();
        int n = 0;
        while (n < 300 && pending() > 0) begin @(posedge aclk); #1; n++; end
        repeat (3) begin @(posedge aclk); #1; end
        chk("drain_pending", pending(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        areset = 1'b1;
        for (int i = 0; i < NM; i++) begin
            m_awaddr[i] = '0; m_araddr[i] = '0; m_wdata[i] = '0; m_wstrb[i] = '0;
            m_awvalid[i] = 1'b0; m_wvalid[i] = 1'b0; m_arvalid[i] = 1'b0;
        end
        repeat (3) @(posedge aclk);
        #1 chk("reset_outputs", any_out(), 1'b0);
        @(negedge aclk) areset = 1'b0;

        // Reset in the middle of a write: AW accepted, W never supplied.
        @(posedge aclk); #1;
        m_awaddr[0] = 32'h4; m_awvalid[0] = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        chk("aw_grant_latency", slv_awvalid, 2'b01);
        @(negedge aclk);
        #2 areset = 1'b1;
        #1 chk("async_reset_outputs", any_out(), 1'b0);
        repeat (2) @(posedge aclk);
        #1 chk("held_reset_outputs", any_out(), 1'b0);
        m_awvalid[0] = 1'b0;
        @(negedge aclk) areset = 1'b0;
        @(posedge aclk); #1;

        // Both masters stream writes: after reset master 0 wins, then strict alternation.
        exp_sw.push_back(mk(0, 32'h0, 32'hA000_0000, 4'hF));
        exp_sw.push_back(mk(0, 32'h8, 32'hA100_0000, 4'h3));
        exp_sw.push_back(mk(0, 32'h4, 32'hA000_0001, 4'hF));
        exp_sw.push_back(mk(0, 32'hC, 32'hA100_0001, 4'hC));
        for (int k = 0; k < 2; k++) begin exp_b[0].push_back(2'b00); exp_b[1].push_back(2'b00); end
        fork
            begin wr(0, 32'h0, 32'hA000_0000, 4'hF, 0); wr(0, 32'h4, 32'hA000_0001, 4'hF, 0); end
            begin wr(1, 32'h8, 32'hA100_0000, 4'h3, 0); wr(1, 32'hC, 32'hA100_0001, 4'hC, 0); end
        join
        drain();

        // Decode to slave 1 with one-cycle grant latency.
        exp_sr.push_back(mk(1, 32'h14, 0, 0));
        exp_r[0].push_back({32'hCAFE0001, 2'b00});
        fork
            rd(0, 32'h14);
            begin
                @(negedge aclk); chk("ar_before_grant", slv_arvalid, 2'b00);
                @(negedge aclk); chk("ar_after_grant", slv_arvalid, 2'b10);
            end
        join
        drain();

        // Simultaneous write (m1 -> slave 0) and read (m0 -> slave 1).
        exp_sw.push_back(mk(0, 32'h4, 32'h5555_AAAA, 4'h6));
        exp_b[1].push_back(2'b00);
        exp_sr.push_back(mk(1, 32'h18, 0, 0));
        exp_r[0].push_back({32'hCAFE0001, 2'b00});
        fork
            wr(1, 32'h4, 32'h5555_AAAA, 4'h6, 0);
            rd(0, 32'h18);
            begin
                @(negedge aclk);
                @(negedge aclk); chk("concurrent_grant", {slv_awvalid, slv_arvalid}, 4'b0110);
            end
        join
        drain();

        // W trails AW by three cycles; then a write routed to slave 1 (bresp 01).
        exp_sw.push_back(mk(0, 32'h4, 32'h0BAD_F00D, 4'h5));
        exp_b[1].push_back(2'b00);
        wr(1, 32'h4, 32'h0BAD_F00D, 4'h5, 3);
        drain();
        exp_sw.push_back(mk(1, 32'h1C, 32'h1234_0001, 4'hF));
        exp_b[0].push_back(2'b01);
        wr(0, 32'h1C, 32'h1234_0001, 4'hF, 0);
        drain();

        // Unmapped addresses.
`ifdef AXIL_XBAR_DECERR_EN
        exp_b[0].push_back(2'b11);
        exp_r[1].push_back({32'h0, 2'b11});
`else
        exp_sw.push_back(mk(0, 32'h100, 32'h8765_4321, 4'hF));
        exp_b[0].push_back(2'b00);
        exp_sr.push_back(mk(0, 32'h200, 0, 0));
        exp_r[1].push_back({32'hCAFE0000, 2'b00});
`endif
        fork
            wr(0, 32'h100, 32'h8765_4321, 4'hF, 0);
            rd(1, 32'h200);
            begin
                @(negedge aclk);
                @(negedge aclk);
`ifdef AXIL_XBAR_DECERR_EN
                chk("unmapped_aw_route", slv_awvalid, 2'b00);
`else
                chk("unmapped_aw_route", {slv_awvalid, slv_awaddr[31:0]}, {2'b01, 32'h100});
`endif
            end
        join
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axil_xbar_rr.md
Name: axil_xbar_rr

Overview:
Parametrised NUM_MASTER x NUM_SLAVE AXI4-Lite interconnect, the successor to the team's fixed 2x2 interconnect.
- Separate read and write paths, each with its own round-robin arbiter and FSM, so one read and one write can be in flight at the same time.
- Address decode uses per-slave base/mask parameter tables.
- Sits between CPU/DMA masters and peripheral slaves.

Parameters:
- NUM_MASTER, 2, number of upstream masters (>=1).
- NUM_SLAVE, 2, number of downstream slaves (>=1).
- ADDR_W, 32, address width.
- DATA_W, 32, data width (multiple of 8); STRB_W = DATA_W/8.
- SLV_BASE, {32'h10, 32'h0}, packed NUM_SLAVE*ADDR_W vector; slice j is the base of slave j.
- SLV_MASK, {32'hFFFFFFF0, 32'hFFFFFFF0}, packed NUM_SLAVE*ADDR_W vector; slave j matches when (addr & mask_j) == base_j.

Ports:
Notation: N = NUM_MASTER, S = NUM_SLAVE; every mst_/slv_ signal is packed, slice i belongs to master i / slave i.
- aclk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- mst_awaddr, mst_araddr  in  N*ADDR_W  master write/read addresses
- mst_awvalid, mst_wvalid, mst_arvalid, mst_bready, mst_rready  in  N  master valids/readies
- mst_wdata  in  N*DATA_W;  mst_wstrb  in  N*STRB_W
- mst_awready, mst_wready, mst_arready, mst_bvalid, mst_rvalid  out  N
- mst_bresp, mst_rresp  out  N*2;  mst_rdata  out  N*DATA_W
- slv_awaddr, slv_araddr  out  S*ADDR_W
- slv_awvalid, slv_wvalid, slv_arvalid, slv_bready, slv_rready  out  S
- slv_wdata  out  S*DATA_W;  slv_wstrb  out  S*STRB_W
- slv_awready, slv_wready, slv_arready, slv_bvalid, slv_rvalid  in  S
- slv_bresp, slv_rresp  in  S*2;  slv_rdata  in  S*DATA_W

Behaviour:
Reset (areset high, asynchronous):
- Both FSMs go to IDLE; both round-robin pointers go to NUM_MASTER-1, so master 0 wins first.
- All outputs are 0; there is no combinational path that can raise a valid or ready during reset.
- Reset mid-transaction abandons the transaction; no response is generated.

Write FSM (W_IDLE, W_ADDR, W_RESP):
- W_IDLE: request vector = mst_awvalid. The arbiter grants the first requester at index (ptr+1 .. ptr+N) mod N.
- At the same edge it registers wgnt, decodes the granted awaddr into wsel, sets ptr = wgnt and moves to W_ADDR.
- Decode: lowest-index matching slave wins; no match means the default target (see Optional Feature).
- W_ADDR: AW and W of master wgnt are routed to slave wsel.
  - aw_done and w_done are tracked independently; each channel is forwarded only until its own handshake.
  - Go to W_RESP when both are done, including the same cycle both complete.
- W_RESP: slave wsel's bvalid/bresp are routed to master wgnt, and bready is routed back. Return to W_IDLE on the bvalid&bready handshake.

Read FSM (R_IDLE, R_ADDR, R_DATA): same structure as write.
- AR is routed in R_ADDR.
- R_DATA routes rdata/rresp/rvalid and rready; it returns to R_IDLE on rvalid&rready.

Routing and latency:
- Non-granted masters and non-selected slaves see every valid/ready = 0 and data = 0.
- wsel/rsel stay stable for the whole transaction; master address changes after grant are ignored.
- Routing is combinational once granted; grant latency is 1 cycle.
- Minimum cost is 3 cycles per transaction per path, because one idle cycle sits between transactions.
- Read and write paths never block each other, even when both target the same slave.

Optional Feature:
Macro: AXIL_XBAR_DECERR_EN.
- Defined: an unmapped address targets an internal error responder.
  - In W_ADDR it drives awready = wready = 1; in W_RESP it drives bvalid = 1, bresp = 2'b11.
  - In R_ADDR it drives arready = 1; in R_DATA it drives rvalid = 1, rdata = 0, rresp = 2'b11.
  - No slave sees any valid.
- Undefined: unmapped addresses route to slave 0 (legacy behaviour), and the error responder logic is absent.

Test Plan:
- Reset: areset pulsed mid-write (W_ADDR) -> all outputs 0 immediately, FSM in W_IDLE; the next request from master 0 is granted.
- Decode: master 0 reads 0x14 -> slv_arvalid[1] = 1 one cycle later, slave 1 returns 0xCAFE0001 with OKAY -> mst_rdata[0] = 0xCAFE0001, mst_rresp[0] = 0.
- Round-robin: masters 0 and 1 issue back-to-back writes continuously -> grants alternate 0,1,0,1; no master is granted twice in a row while the other waits.
- Concurrency and channel ordering: master 1 writes 0x4 while master 0 reads 0x18 in the same cycle -> both granted the same cycle; slave 1's R and slave 0's B complete independently. Same write with wvalid 3 cycles after awvalid -> W_RESP entered only after the W handshake.
- DECERR (macro defined): master 0 writes 0x100 -> no slave sees awvalid, mst_bresp[0] = 2'b11. Macro undefined -> slv_awvalid[0] = 1 with awaddr 0x100.
